// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit validity helper for the
// two-digit BCD to binary converter.
package bcd_pkg;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int ITER   = 7;
  localparam int NIB_W  = 4;
  localparam int WORK_W = DIGITS * NIB_W + BIN_W;
  localparam int CNT_W  = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // True when every nibble of the packed BCD word is a legal decimal digit.
  function automatic logic bcd_digits_valid(input logic [DIGITS*NIB_W-1:0] sw);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sw[i*NIB_W +: NIB_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_binary_2_digits_if.sv
// Request/result bundle of the BCD to binary converter. The err signal is
// present only when BCD_BIN_ERR_CHECK_EN is defined.
interface bcd_binary_2_digits_if;
  import bcd_pkg::*;

  logic [0:DIGITS*NIB_W-1] SW;
  logic                    start;
  logic [0:BIN_W-1]        bin;
  logic                    busy;
  logic                    done;
`ifdef BCD_BIN_ERR_CHECK_EN
  logic                    err;

  modport master (output SW, start, input bin, busy, done, err);
  modport slave  (input SW, start, output bin, busy, done, err);
`else
  modport master (output SW, start, input bin, busy, done);
  modport slave  (input SW, start, output bin, busy, done);
`endif

endinterface

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD nibble: after the right
// shift, a digit of 8 or more has received a carried-in half (weight 8 that
// should be 5), so 3 is removed.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q
);

  // Subtract 3 from nibbles >= 8, pass others unchanged.
  always_comb begin
    q = d;
    if (d >= 4'd8) q = d - 4'd3;
  end

endmodule

// File: rtl/bcd_binary_2_digits.sv
// Sequential two-digit BCD to 7-bit binary converter using reverse
// double-dabble, one shift/correct iteration per clock.
// Optional feature macro: BCD_BIN_ERR_CHECK_EN (reject non-decimal nibbles
// with a one-cycle err pulse instead of converting them).
module bcd_binary_2_digits
  import bcd_pkg::*;
(
  input logic                  CLOCK_50,
  input logic                  RESET,
  bcd_binary_2_digits_if.slave bus
);

  state_t              state;
  state_t              state_n;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   adjusted;
  logic [CNT_W-1:0]    cnt;
  logic [BIN_W-1:0]    bin_q;
  logic                accept;
  logic                last_iter;

`ifdef BCD_BIN_ERR_CHECK_EN
  logic                in_ok;
  logic                err_q;

  assign in_ok  = bcd_digits_valid(bus.SW);
  assign accept = bus.start && in_ok;
  assign bus.err = err_q;
`else
  assign accept = bus.start;
`endif

  // Work register layout: {tens, units, binary}; the binary field fills
  // from the top as the BCD value drains out of the nibbles.
  assign shifted = work >> 1;
  assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (shifted [BIN_W + g*NIB_W +: NIB_W]),
      .q (adjusted[BIN_W + g*NIB_W +: NIB_W])
    );
  end

  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic: load on accepted start, seven shifts, one DONE cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = SHIFT;
      SHIFT:   if (last_iter) state_n = DONE;
      DONE:                   state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Work register, iteration counter, result and error pulse.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      work  <= '0;
      cnt   <= '0;
      bin_q <= '0;
`ifdef BCD_BIN_ERR_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
`ifdef BCD_BIN_ERR_CHECK_EN
      err_q <= (state == IDLE) && bus.start && !in_ok;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            work <= {bus.SW, {BIN_W{1'b0}}};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          work <= adjusted;
          cnt  <= cnt + 1'b1;
          if (last_iter) bin_q <= adjusted[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.bin  = bin_q;

endmodule
